// File: rtl/uart_pkg.sv
// Shared definitions for the UART register responder: response codes,
// FSM state encoding, command byte field positions and the status address.
package uart_pkg;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  // Command byte layout: [7] write flag, [6:4] reserved (must be 0), [3:0] address
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  // Address that maps to the read-only status input instead of storage
  localparam logic [3:0] STATUS_ADDR = 4'hF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } state_t;

  // A command is well formed only when its reserved field is all zero
  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return cmd[CMD_RSV_HI:CMD_RSV_LO] == 3'b000;
  endfunction

endpackage

// File: rtl/uart_regfile.sv
// Register storage for the UART register responder.
// Fifteen 8-bit read/write registers at addresses 0x0-0xE; address 0xF reads
// the live status input.
// Ports:
//   i_clk, i_rst      clock and synchronous active-high reset (clears storage)
//   i_we              write strobe, registers i_wdata into i_waddr on the edge
//   i_waddr, i_wdata  write address and data
//   i_raddr           combinational read address
//   i_status          status byte returned for address 0xF
//   o_rdata           read data for i_raddr
//   o_ctrl            current value of register 0x0
module uart_regfile
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  input  logic [7:0] i_status,
  output logic [7:0] o_rdata,
  output logic [7:0] o_ctrl
);

  logic [7:0] r_regs [0:14];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 15; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_we && (i_waddr != STATUS_ADDR)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = i_status;
    if (i_raddr != STATUS_ADDR) begin
      o_rdata = r_regs[i_raddr];
    end
  end

  assign o_ctrl = r_regs[0];

endmodule

// File: rtl/uart_reg_responder.sv
// Byte-command register responder sitting behind a UART RX/TX FIFO pair.
// Reads a command byte (and, for writes, one data byte) from the RX FIFO and
// pushes exactly one response byte to the TX FIFO: register value for reads,
// ACK for good writes, NAK for malformed commands, writes to 0xF or a write
// whose data byte does not arrive within TIMEOUT_CYCLES.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   rx_empty, data_out    RX FIFO empty flag and first-word-fall-through head
//   rd_uart               one-cycle RX pop
//   tx_full, data_in      TX FIFO full flag and byte to push
//   wr_uart               one-cycle TX push
//   status_in             status byte readable at address 0xF
//   ctrl_out              register 0x0
//   err_count             saturating count of NAKs sent
//   busy                  FSM not in IDLE
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 104166
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] data_out,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] data_in,
  output logic       wr_uart,
  input  logic [7:0] status_in,
  output logic [7:0] ctrl_out,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [7:0]         r_cmd;
  logic [7:0]         r_resp;
  logic               r_resp_nak;
  logic [TIMER_W-1:0] r_timer;
  logic               r_rd_uart;
  logic               r_wr_uart;
  logic [7:0]         r_data_in;
  logic [7:0]         r_err_count;

  logic [3:0]         w_addr;
  logic               w_cmd_ok;
  logic               w_we;
  logic [7:0]         w_rdata;
  logic [7:0]         w_ctrl;

  assign w_addr   = r_cmd[CMD_ADDR_HI:CMD_ADDR_LO];
  assign w_cmd_ok = cmd_is_valid(r_cmd);
  // The data byte is written on the same edge it is popped
  assign w_we     = (r_state == WAIT_DATA) && !rx_empty && (w_addr != STATUS_ADDR);

  uart_regfile u_regfile (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_we     (w_we),
    .i_waddr  (w_addr),
    .i_wdata  (data_out),
    .i_raddr  (w_addr),
    .i_status (status_in),
    .o_rdata  (w_rdata),
    .o_ctrl   (w_ctrl)
  );

  // r_cmd and r_resp are data holding registers; they are only consumed after
  // the FSM reloads them, so reset leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_rd_uart   <= 1'b0;
      r_wr_uart   <= 1'b0;
      r_data_in   <= 8'h00;
      r_err_count <= 8'h00;
      r_resp_nak  <= 1'b0;
    end else begin
      r_rd_uart <= 1'b0;
      r_wr_uart <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!rx_empty) begin
            r_cmd     <= data_out;
            r_rd_uart <= 1'b1;
            r_state   <= DECODE;
          end
        end
        DECODE: begin
          if (!w_cmd_ok) begin
            r_resp     <= NAK;
            r_resp_nak <= 1'b1;
            r_state    <= RESP;
          end else if (!r_cmd[CMD_WR_BIT]) begin
            // status_in is sampled here for address 0xF
            r_resp     <= w_rdata;
            r_resp_nak <= 1'b0;
            r_state    <= RESP;
          end else begin
            r_timer <= '0;
            r_state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (!rx_empty) begin
            r_rd_uart <= 1'b1;
            if (w_addr == STATUS_ADDR) begin
              r_resp     <= NAK;
              r_resp_nak <= 1'b1;
            end else begin
              r_resp     <= ACK;
              r_resp_nak <= 1'b0;
            end
            r_state <= RESP;
          end else if (r_timer == TIMER_LAST) begin
            r_resp     <= NAK;
            r_resp_nak <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          // Held here with the response intact until the TX FIFO has room
          if (!tx_full) begin
            r_wr_uart <= 1'b1;
            r_data_in <= r_resp;
            if (r_resp_nak && (r_err_count != 8'hFF)) begin
              r_err_count <= r_err_count + 8'd1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_uart   = r_rd_uart;
  assign wr_uart   = r_wr_uart;
  assign data_in   = r_data_in;
  assign err_count = r_err_count;
  assign ctrl_out  = w_ctrl;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: stimulus pushes bytes into a
// modelled RX FIFO and the expected response into a queue; a monitor pops and
// compares on every wr_uart pulse.
module tb_uart_reg_responder;

  localparam int TO = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] data_out;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] data_in;
  logic       wr_uart;
  logic [7:0] status_in;
  logic [7:0] ctrl_out;
  logic [7:0] err_count;
  logic       busy;

  uart_reg_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .data_out  (data_out),
    .rd_uart   (rd_uart),
    .tx_full   (tx_full),
    .data_in   (data_in),
    .wr_uart   (wr_uart),
    .status_in (status_in),
    .ctrl_out  (ctrl_out),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  logic [7:0] rx_q  [$];
  logic [7:0] exp_q [$];
  logic [7:0] m_regs [16];
  int         m_err;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         rd_total = 0;
  int         wr_total = 0;
  int         last_wr_cyc = 0;
  logic       prev_wr = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic rx_update();
    rx_empty = (rx_q.size() == 0);
    data_out = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // RX FIFO model: pop on the cycle rd_uart is seen high
  always @(negedge clock) begin
    if (rd_uart === 1'b1) begin
      rd_total++;
      if (rx_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_underflow: got pop with empty fifo required no pop");
      end else begin
        void'(rx_q.pop_front());
      end
    end
    rx_update();
  end

  // Response monitor
  always @(negedge clock) begin
    logic [7:0] e;
    if (rd_uart === 1'b1 && wr_uart === 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL rd_wr_overlap: got both high required exclusive");
    end
    if (wr_uart === 1'b1) begin
      wr_total++;
      last_wr_cyc = cyc;
      if (prev_wr) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_pulse: got back-to-back wr_uart required single pulse");
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got %02h required no response", data_in);
      end else begin
        e = exp_q.pop_front();
        check("resp", data_in, e);
      end
    end
    prev_wr = (wr_uart === 1'b1);
  end

  // Reference model of one transaction, expressed from the command rules
  task automatic issue(input logic [7:0] cmd, input logic [7:0] data);
    logic [3:0] a;
    logic [7:0] r;
    bit         nak;
    a   = cmd[3:0];
    r   = 8'h00;
    nak = 1'b0;
    if (cmd[6:4] != 3'b000) nak = 1'b1;
    else if (!cmd[7]) r = (a == 4'hF) ? status_in : m_regs[a];
    else if (a == 4'hF) nak = 1'b1;
    else begin
      m_regs[a] = data;
      r = 8'hA5;
    end
    if (nak) begin
      r = 8'h5A;
      if (m_err < 255) m_err++;
    end
    exp_q.push_back(r);
    rx_q.push_back(cmd);
    if (cmd[7] && cmd[6:4] == 3'b000) rx_q.push_back(data);
    rx_update();
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && rx_q.size() == 0 && busy === 1'b0 && wr_uart === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         t0, rd0, w0, nb, kind;
    logic [7:0] prev_ctrl, cmd;

    reset     = 1'b1;
    tx_full   = 1'b0;
    status_in = 8'h00;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_err = 0;
    rx_update();
    repeat (3) tick();
    check("rst_rd", rd_uart, 0);
    check("rst_wr", wr_uart, 0);
    check("rst_busy", busy, 0);
    check("rst_data_in", data_in, 8'h00);
    check("rst_ctrl", ctrl_out, 8'h00);
    check("rst_err", err_count, 8'h00);
    reset = 1'b0;
    tick();

    // Write then read back, with read latency
    issue(8'h83, 8'h3C);
    drain(50);
    t0 = cyc;
    issue(8'h03, 8'h00);
    drain(50);
    check("read_latency", last_wr_cyc - t0, 3);
    check("err_s1", err_count, 8'h00);

    // ctrl_out follows register 0x0 write
    rd0 = rd_total;
    issue(8'h80, 8'h55);
    prev_ctrl = ctrl_out;
    for (int i = 0; i < 20; i++) begin
      prev_ctrl = ctrl_out;
      tick();
      if (rd_total == rd0 + 2) break;
    end
    check("data_pop", rd_total - rd0, 2);
    check("ctrl_before", prev_ctrl, 8'h00);
    check("ctrl_after", ctrl_out, 8'h55);
    drain(50);
    issue(8'h00, 8'h00);
    drain(50);

    // Status read and write to 0xF
    status_in = 8'hC3;
    issue(8'h0F, 8'h00);
    drain(50);
    rd0 = rd_total;
    issue(8'h8F, 8'h11);
    drain(50);
    check("nak_f_pops", rd_total - rd0, 2);
    check("err_s3", err_count, 8'h01);

    // Malformed command consumes only itself
    rd0 = rd_total;
    issue(8'h90, 8'h00);
    issue(8'h02, 8'h00);
    drain(50);
    check("bad_cmd_pops", rd_total - rd0, 2);
    check("err_s4", err_count, 8'h02);

    // Write data timeout leaves the register alone
    issue(8'h81, 8'h77);
    drain(50);
    t0 = cyc;
    rx_q.push_back(8'h81);
    rx_update();
    exp_q.push_back(8'h5A);
    m_err++;
    drain(TO * 3);
    check_range("timeout_latency", last_wr_cyc - t0, TO, TO + 4);
    issue(8'h01, 8'h00);
    drain(50);
    check("err_s5", err_count, m_err[7:0]);

    // Back-pressure on the TX FIFO
    w0 = wr_total;
    tx_full = 1'b1;
    issue(8'h03, 8'h00);
    repeat (20) tick();
    check("txfull_hold", wr_total - w0, 0);
    check("txfull_busy", busy, 1);
    tx_full = 1'b0;
    drain(50);
    repeat (5) tick();
    check("txfull_release", wr_total - w0, 1);

    // Randomized batches
    for (int b = 0; b < 40; b++) begin
      status_in = 8'($urandom);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        kind = $urandom_range(0, 9);
        if (kind < 4) cmd = {4'h0, 4'($urandom_range(0, 15))};
        else if (kind < 8) cmd = {4'h8, 4'($urandom_range(0, 15))};
        else cmd = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), 4'($urandom_range(0, 15))};
        issue(cmd, 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        tx_full = 1'b1;
        repeat ($urandom_range(1, 8)) tick();
        tx_full = 1'b0;
      end
      drain(60 * nb);
      check("rand_err", err_count, m_err[7:0]);
      check("rand_ctrl", ctrl_out, m_regs[0]);
    end

    // err_count saturation
    for (int b = 0; b < 13; b++) begin
      for (int k = 0; k < 20; k++) issue(8'h10, 8'h00);
      drain(400);
    end
    check("err_sat", err_count, 8'hFF);

    // Reset while waiting for write data
    rd0 = rd_total;
    w0  = wr_total;
    rx_q.push_back(8'h81);
    rx_update();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_total == rd0 + 1) break;
    end
    repeat (3) tick();
    check("wait_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("wrst_busy", busy, 0);
    check("wrst_rd", rd_uart, 0);
    check("wrst_wr", wr_uart, 0);
    check("wrst_data_in", data_in, 8'h00);
    check("wrst_ctrl", ctrl_out, 8'h00);
    check("wrst_err", err_count, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_err = 0;
    repeat (30) tick();
    check("wrst_no_resp", wr_total - w0, 0);
    status_in = 8'h3D;
    for (int a = 0; a < 16; a++) begin
      issue({4'h0, 4'(a)}, 8'h00);
      drain(50);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
